// File: rtl/sram_channel_bridge_pkg.sv
// Shared types for the SRAM channel bridge: per-source request lifecycle.
package sram_channel_bridge_pkg;

  typedef enum logic [1:0] {
    SRC_IDLE   = 2'd0,
    SRC_ISSUED = 2'd1,
    SRC_DONE   = 2'd2
  } src_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/sram_channel_bridge.sv
// Serializes per-channel read/write valid/ready requests onto one single-port
// synchronous SRAM through a round-robin arbiter.
module sram_channel_bridge
  import sram_channel_bridge_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read_valid    [NUM_CHANNELS],
  input  logic [ADDR_BITS-1:0] mem_read_address  [NUM_CHANNELS],
  output logic                 mem_read_ready    [NUM_CHANNELS],
  output logic [DATA_BITS-1:0] mem_read_data     [NUM_CHANNELS],
  input  logic                 mem_write_valid   [NUM_CHANNELS],
  input  logic [ADDR_BITS-1:0] mem_write_address [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0] mem_write_data    [NUM_CHANNELS],
  output logic                 mem_write_ready   [NUM_CHANNELS],
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_wdata,
  input  logic [DATA_BITS-1:0] sram_rdata
);

  localparam int NS = 2 * NUM_CHANNELS;
  localparam int SW = $clog2(NS);

  src_state_t           state [NS];
  logic [NS-1:0]        src_valid;
  logic [NS-1:0]        src_req;
  logic [NS-1:0]        grant;
  logic [SW-1:0]        grant_idx;
  logic                 any_grant;
  logic [SW-1:0]        rr_ptr;
  logic                 cmd_we;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [DATA_BITS-1:0] cmd_wdata;
  logic                 stage1_valid;
  logic                 stage2_valid;
  logic [SW-1:0]        stage1_src;
  logic [SW-1:0]        stage2_src;

  // Sources 0..N-1 are read channels, N..2N-1 the matching write channels.
  always_comb begin
    src_valid = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      src_valid[c]                = mem_read_valid[c];
      src_valid[NUM_CHANNELS + c] = mem_write_valid[c];
    end
  end

  always_comb begin
    src_req = '0;
    for (int s = 0; s < NS; s++) src_req[s] = src_valid[s] && (state[s] == SRC_IDLE);
  end

  rr_arbiter #(.N(NS), .IW(SW)) u_arbiter (
    .req       (src_req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant[c]) cmd_addr = mem_read_address[c];
      if (grant[NUM_CHANNELS + c]) begin
        cmd_we    = 1'b1;
        cmd_addr  = mem_write_address[c];
        cmd_wdata = mem_write_data[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      mem_read_ready[c]  = (state[c] == SRC_DONE);
      mem_write_ready[c] = (state[NUM_CHANNELS + c] == SRC_DONE);
    end
  end

  // ISSUED spans the command cycle and the SRAM data-return cycle; the
  // two-stage grant pipeline marks the edge at which the access has completed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NS; s++) state[s] <= SRC_IDLE;
      rr_ptr       <= '0;
      sram_en      <= 1'b0;
      sram_we      <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      stage1_valid <= 1'b0;
      stage1_src   <= '0;
      stage2_valid <= 1'b0;
      stage2_src   <= '0;
    end else begin
      for (int s = 0; s < NS; s++) begin
        case (state[s])
          SRC_IDLE:   if (grant[s]) state[s] <= SRC_ISSUED;
          SRC_ISSUED: if (stage2_valid && stage2_src == SW'(s)) state[s] <= SRC_DONE;
          SRC_DONE:   if (!src_valid[s]) state[s] <= SRC_IDLE;
          default:    state[s] <= SRC_IDLE;
        endcase
      end
      if (any_grant) rr_ptr <= (grant_idx == SW'(NS - 1)) ? '0 : grant_idx + 1'b1;
      sram_en <= any_grant;
      if (any_grant) begin
        sram_we   <= cmd_we;
        sram_addr <= cmd_addr;
        if (cmd_we) sram_wdata <= cmd_wdata;
      end
      stage1_valid <= any_grant;
      stage1_src   <= grant_idx;
      stage2_valid <= stage1_valid;
      stage2_src   <= stage1_src;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) mem_read_data[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (stage2_valid && stage2_src == SW'(c)) mem_read_data[c] <= sram_rdata;
    end
  end

endmodule
